// File: rtl/dataformat.sv
// Shared packet format and writeback state encoding for the ofmap writeback node.
// Packet layout is {src, dst, payload}; src is carried but never used for placement.
package dataformat;
   localparam int ADDR_W = 5;
   localparam int PAY_W  = 10;
   localparam int DATA_W = 2 * ADDR_W + PAY_W;

   typedef struct packed {
      logic [ADDR_W-1:0] src;
      logic [ADDR_W-1:0] dst;
      logic [PAY_W-1:0]  payload;
   } pkt_t;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      NOTIFY,
      DONE
   } wb_state_t;

   function automatic logic [ADDR_W-1:0] get_dst(input logic [DATA_W-1:0] d);
      pkt_t p;
      p = pkt_t'(d);
      return p.dst;
   endfunction

   function automatic logic [PAY_W-1:0] get_payload(input logic [DATA_W-1:0] d);
      pkt_t p;
      p = pkt_t'(d);
      return p.payload;
   endfunction
endpackage

// File: rtl/ofmap_writeback_if.sv
// Handshake bundle between the writeback node and its router / control / reader peers.
// The DUT side uses the slave modport; the driving environment uses master.
interface ofmap_writeback_if
   import dataformat::*;
#(
   parameter int TOT_NUM = 9
);
   localparam int AW = $clog2(TOT_NUM);

   logic              start_valid;
   logic              start_ready;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              done_valid;
   logic              done_ready;
   logic              rd_en;
   logic [AW-1:0]     rd_addr;
   logic [PAY_W-1:0]  rd_data;
   logic              rd_valid;
   logic [7:0]        drop_cnt;

   modport master (
      output start_valid, in_valid, in_data, done_ready, rd_en, rd_addr,
      input  start_ready, in_ready, done_valid, rd_data, rd_valid, drop_cnt
   );

   modport slave (
      input  start_valid, in_valid, in_data, done_ready, rd_en, rd_addr,
      output start_ready, in_ready, done_valid, rd_data, rd_valid, drop_cnt
   );
endinterface

// File: rtl/ofmap_buf.sv
// Output feature map register file: async clear, one write port, registered read.
// Out-of-range read addresses return zero.
module ofmap_buf #(
   parameter int DEPTH = 9,
   parameter int W     = 10,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata,
   output logic          rvalid
);
   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] mem_d [DEPTH];
   logic [W-1:0] rdata_q, rdata_d;
   logic         rvalid_q, rvalid_d;

   always_comb begin
      mem_d    = mem_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      if (we && int'(waddr) < DEPTH) mem_d[waddr] = wdata;
      if (re) begin
         rvalid_d = 1'b1;
         rdata_d  = (int'(raddr) < DEPTH) ? mem_q[raddr] : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign rdata  = rdata_q;
   assign rvalid = rvalid_q;
endmodule

// File: rtl/ofmap_writeback.sv
// Collects TOT_NUM output-pixel packets into the ofmap buffer, then issues a done token.
// Define OFMAP_WB_RELU_EN to clamp negative (signed) payloads to zero at write time.
module ofmap_writeback
   import dataformat::*;
#(
   parameter int TOT_NUM  = 9,
   parameter int MY_INDEX = 0
) (
   input logic              clk,
   input logic              rst,
   ofmap_writeback_if.slave bus
);
   localparam int AW = $clog2(TOT_NUM);
   localparam logic [AW-1:0] LAST = AW'(TOT_NUM - 1);

   wb_state_t        state_q, state_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [7:0]       drop_q, drop_d;
   logic             we;
   logic [PAY_W-1:0] pay;
   logic [PAY_W-1:0] wdata;
   logic             dst_ok;

   assign pay    = get_payload(bus.in_data);
   assign dst_ok = get_dst(bus.in_data) == ADDR_W'(MY_INDEX);

`ifdef OFMAP_WB_RELU_EN
   assign wdata = pay[PAY_W-1] ? '0 : pay;
`else
   assign wdata = pay;
`endif

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      drop_d   = drop_q;
      we       = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (bus.start_valid) begin
               state_d  = COLLECT;
               wr_ptr_d = '0;
               drop_d   = '0;
            end
         end
         COLLECT: begin
            if (bus.in_valid && dst_ok) begin
               we = 1'b1;
               // pointer parks on the last slot so it never runs past the buffer
               if (wr_ptr_q == LAST) state_d = NOTIFY;
               else wr_ptr_d = wr_ptr_q + 1'b1;
            end else if (bus.in_valid && drop_q != 8'hFF) begin
               drop_d = drop_q + 8'd1;
            end
         end
         NOTIFY: begin
            if (bus.done_ready) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         drop_q   <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         drop_q   <= drop_d;
      end
   end

   assign bus.start_ready = (state_q == IDLE) || (state_q == DONE);
   assign bus.in_ready    = (state_q == COLLECT);
   assign bus.done_valid  = (state_q == NOTIFY);
   assign bus.drop_cnt    = drop_q;

   ofmap_buf #(
      .DEPTH(TOT_NUM),
      .W    (PAY_W),
      .AW   (AW)
   ) u_buf (
      .clk   (clk),
      .rst   (rst),
      .we    (we),
      .waddr (wr_ptr_q),
      .wdata (wdata),
      .re    (bus.rd_en && state_q == DONE),
      .raddr (bus.rd_addr),
      .rdata (bus.rd_data),
      .rvalid(bus.rd_valid)
   );
endmodule

// File: tb/tb_ofmap_writeback.sv
// Randomized scenario bench for ofmap_writeback with an array-based reference buffer.
// Honours OFMAP_WB_RELU_EN in its expected stored values.
module tb_ofmap_writeback;
   import dataformat::*;

   localparam int TOT = 9;
   localparam int AW  = $clog2(TOT);

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ofmap_writeback_if #(.TOT_NUM(TOT)) bus ();

   ofmap_writeback #(.TOT_NUM(TOT), .MY_INDEX(0)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int vecs = 0;
   int errs = 0;
   logic [PAY_W-1:0] ref_mem [TOT];

   function automatic logic [PAY_W-1:0] stored(input logic [PAY_W-1:0] p);
`ifdef OFMAP_WB_RELU_EN
      return ($signed(p) < 0) ? '0 : p;
`else
      return p;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      bus.start_valid = 1'b1;
      tick();
      bus.start_valid = 1'b0;
   endtask

   task automatic push(input logic [ADDR_W-1:0] dst, input logic [PAY_W-1:0] pay);
      bus.in_data  = {ADDR_W'($urandom), dst, pay};
      bus.in_valid = 1'b1;
      tick();
   endtask

   task automatic ack_done();
      bus.done_ready = 1'b1;
      tick();
      bus.done_ready = 1'b0;
   endtask

   task automatic do_read(input int idx);
      bus.rd_en   = 1'b1;
      bus.rd_addr = AW'(idx);
      tick();
      bus.rd_en   = 1'b0;
   endtask

   task automatic good_pass();
      logic [PAY_W-1:0] p;
      do_start();
      for (int i = 0; i < TOT; i++) begin
         p = PAY_W'($urandom);
         push(0, p);
         ref_mem[i] = stored(p);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      vecs++;
      if (bus.start_ready !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.done_valid !== 1'b0 || bus.rd_valid !== 1'b0 ||
          bus.rd_data !== '0 || bus.drop_cnt !== 8'd0) begin
         errs++;
         $display("FAIL reset: sr=%b ir=%b dv=%b rv=%b rd=%h dc=%0d want 1 0 0 0 0 0",
                  bus.start_ready, bus.in_ready, bus.done_valid,
                  bus.rd_valid, bus.rd_data, bus.drop_cnt);
      end
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      do_start();
      vecs++;
      if (bus.in_ready !== 1'b1) begin
         errs++;
         $display("FAIL basic_inready: got %b want 1", bus.in_ready);
      end
      for (int i = 0; i < TOT; i++) begin
         push(0, PAY_W'(i + 1));
         ref_mem[i] = stored(PAY_W'(i + 1));
         if (i == TOT - 2) begin
            vecs++;
            if (bus.done_valid !== 1'b0) begin
               errs++;
               $display("FAIL basic_early_done: got %b want 0", bus.done_valid);
            end
         end
      end
      bus.in_valid = 1'b0;
      vecs++;
      if (bus.done_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
         errs++;
         $display("FAIL basic_done: dv=%b ir=%b want 1 0", bus.done_valid, bus.in_ready);
      end
      ack_done();
      vecs++;
      if (bus.done_valid !== 1'b0 || bus.start_ready !== 1'b1) begin
         errs++;
         $display("FAIL basic_ack: dv=%b sr=%b want 0 1", bus.done_valid, bus.start_ready);
      end
      for (int i = 0; i < TOT; i++) begin
         do_read(i);
         vecs++;
         if (bus.rd_valid !== 1'b1 || bus.rd_data !== ref_mem[i]) begin
            errs++;
            $display("FAIL basic_rd%0d: got v=%b %h want v=1 %h",
                     i, bus.rd_valid, bus.rd_data, ref_mem[i]);
         end
      end
      vecs++;
      if (bus.drop_cnt !== 8'd0) begin
         errs++;
         $display("FAIL basic_drop: got %0d want 0", bus.drop_cnt);
      end
   endtask

   task automatic test_drops();
      int p1, p2, k;
      logic [PAY_W-1:0] p;
      do_start();
      p1 = $urandom_range(0, 9);
      p2 = (p1 + $urandom_range(1, 9)) % 10;
      k = 0;
      for (int j = 0; j < 11; j++) begin
         p = PAY_W'($urandom);
         if (j == p1) push(3, p);
         else if (j == p2) push(ADDR_W'($urandom_range(1, 31)), p);
         else begin
            push(0, p);
            ref_mem[k] = stored(p);
            k++;
         end
      end
      bus.in_valid = 1'b0;
      vecs++;
      if (bus.drop_cnt !== 8'd2 || bus.done_valid !== 1'b1) begin
         errs++;
         $display("FAIL drops_cnt: dc=%0d dv=%b want 2 1", bus.drop_cnt, bus.done_valid);
      end
      ack_done();
      for (int i = 0; i < TOT; i++) begin
         do_read(i);
         vecs++;
         if (bus.rd_data !== ref_mem[i]) begin
            errs++;
            $display("FAIL drops_rd%0d: got %h want %h", i, bus.rd_data, ref_mem[i]);
         end
      end
      do_start();
      vecs++;
      if (bus.drop_cnt !== 8'd0) begin
         errs++;
         $display("FAIL drops_clear: got %0d want 0", bus.drop_cnt);
      end
      for (int j = 0; j < 260; j++) push(ADDR_W'($urandom_range(1, 31)), PAY_W'($urandom));
      vecs++;
      if (bus.drop_cnt !== 8'd255 || bus.in_ready !== 1'b1) begin
         errs++;
         $display("FAIL drops_sat: dc=%0d ir=%b want 255 1", bus.drop_cnt, bus.in_ready);
      end
      for (int i = 0; i < TOT; i++) begin
         p = PAY_W'($urandom);
         push(0, p);
         ref_mem[i] = stored(p);
      end
      bus.in_valid = 1'b0;
      ack_done();
      vecs++;
      if (bus.drop_cnt !== 8'd255) begin
         errs++;
         $display("FAIL drops_hold: got %0d want 255", bus.drop_cnt);
      end
   endtask

   task automatic test_done_hold();
      good_pass();
      bus.in_data  = {ADDR_W'(0), ADDR_W'(0), PAY_W'($urandom)};
      bus.in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         vecs++;
         if (bus.done_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            errs++;
            $display("FAIL hold_c%0d: dv=%b ir=%b want 1 0", c, bus.done_valid, bus.in_ready);
         end
      end
      bus.in_valid = 1'b0;
      ack_done();
      for (int i = 0; i < TOT; i++) begin
         do_read(i);
         vecs++;
         if (bus.rd_data !== ref_mem[i]) begin
            errs++;
            $display("FAIL hold_rd%0d: got %h want %h", i, bus.rd_data, ref_mem[i]);
         end
      end
   endtask

   task automatic test_reset_abort();
      do_start();
      for (int i = 0; i < 3; i++) push(0, PAY_W'($urandom));
      push(7, PAY_W'($urandom));
      bus.in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      vecs++;
      if (bus.start_ready !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.done_valid !== 1'b0 || bus.rd_valid !== 1'b0 ||
          bus.rd_data !== '0 || bus.drop_cnt !== 8'd0) begin
         errs++;
         $display("FAIL abort_reset: sr=%b ir=%b dv=%b rv=%b rd=%h dc=%0d want 1 0 0 0 0 0",
                  bus.start_ready, bus.in_ready, bus.done_valid,
                  bus.rd_valid, bus.rd_data, bus.drop_cnt);
      end
      for (int i = 0; i < TOT; i++) ref_mem[i] = '0;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         vecs++;
         if (bus.done_valid !== 1'b0 || bus.start_ready !== 1'b1) begin
            errs++;
            $display("FAIL abort_token_c%0d: dv=%b sr=%b want 0 1",
                     c, bus.done_valid, bus.start_ready);
         end
      end
      good_pass();
      ack_done();
      for (int i = 0; i < TOT; i++) begin
         do_read(i);
         vecs++;
         if (bus.rd_data !== ref_mem[i]) begin
            errs++;
            $display("FAIL abort_rd%0d: got %h want %h", i, bus.rd_data, ref_mem[i]);
         end
      end
   endtask

   task automatic test_bad_addr_start();
      logic [PAY_W-1:0] old3;
      logic [PAY_W-1:0] p;
      do_read(12);
      vecs++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== '0) begin
         errs++;
         $display("FAIL oob_rd: got v=%b %h want v=1 0", bus.rd_valid, bus.rd_data);
      end
      old3 = ref_mem[3];
      bus.rd_en       = 1'b1;
      bus.rd_addr     = AW'(3);
      bus.start_valid = 1'b1;
      tick();
      bus.rd_en       = 1'b0;
      bus.start_valid = 1'b0;
      vecs++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== old3 || bus.in_ready !== 1'b1) begin
         errs++;
         $display("FAIL rd_start: got v=%b %h ir=%b want v=1 %h ir=1",
                  bus.rd_valid, bus.rd_data, bus.in_ready, old3);
      end
      do_read(5);
      vecs++;
      if (bus.rd_valid !== 1'b0 || bus.rd_data !== old3) begin
         errs++;
         $display("FAIL rd_collect: got v=%b %h want v=0 %h", bus.rd_valid, bus.rd_data, old3);
      end
      for (int i = 0; i < TOT; i++) begin
         if (i == 2) begin
            vecs++;
            if (bus.start_ready !== 1'b0) begin
               errs++;
               $display("FAIL collect_sr: got %b want 0", bus.start_ready);
            end
            bus.start_valid = 1'b1;
         end
         p = PAY_W'($urandom);
         push(0, p);
         ref_mem[i] = stored(p);
         bus.start_valid = 1'b0;
      end
      bus.in_valid = 1'b0;
      vecs++;
      if (bus.done_valid !== 1'b1) begin
         errs++;
         $display("FAIL start_ignored: dv=%b want 1", bus.done_valid);
      end
      bus.done_ready = 1'b1;
      tick();
      bus.done_ready = 1'b0;
      for (int i = 0; i < TOT; i++) begin
         do_read(i);
         vecs++;
         if (bus.rd_data !== ref_mem[i]) begin
            errs++;
            $display("FAIL start_rd%0d: got %h want %h", i, bus.rd_data, ref_mem[i]);
         end
      end
   endtask

   task automatic test_relu_payload();
      logic [PAY_W-1:0] want0;
`ifdef OFMAP_WB_RELU_EN
      want0 = 10'h000;
`else
      want0 = 10'h3FF;
`endif
      do_start();
      push(0, 10'h3FF);
      push(0, 10'h005);
      for (int i = 2; i < TOT; i++) push(0, PAY_W'($urandom));
      bus.in_valid = 1'b0;
      ack_done();
      do_read(0);
      vecs++;
      if (bus.rd_data !== want0) begin
         errs++;
         $display("FAIL relu_neg: got %h want %h", bus.rd_data, want0);
      end
      do_read(1);
      vecs++;
      if (bus.rd_data !== 10'h005) begin
         errs++;
         $display("FAIL relu_pos: got %h want 005", bus.rd_data);
      end
   endtask

   initial begin
      bus.start_valid = 1'b0;
      bus.in_valid    = 1'b0;
      bus.in_data     = '0;
      bus.done_ready  = 1'b0;
      bus.rd_en       = 1'b0;
      bus.rd_addr     = '0;
      for (int i = 0; i < TOT; i++) ref_mem[i] = '0;
      test_reset();
      test_basic();
      test_drops();
      test_done_hold();
      test_reset_abort();
      test_bad_addr_start();
      test_relu_payload();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
